extrema_scan_datapath: RTL

//  Parametrised successor to the find-max datapath. On start, it streams N words out of a

---
 rtl/extrema_scan_datapath.sv | 111 +++++++++++
 1 files changed

// File: rtl/extrema_scan_datapath.sv
// extrema_scan_datapath: streams n words from a synchronous-read RAM and reports max/min with their offsets
//  clk, reset              clock and synchronous active-high reset
//  start, start_addr, n    scan request, first address and word count (sampled in IDLE)
//  addr, rd_en, rdata      RAM read port; rdata valid RD_LAT cycles after addr/rd_en
//  busy, done, empty_err   status: scan in flight, 1-cycle completion pulse, n==0 flag
//  max, min                extreme words seen
//  max_idx, min_idx        0-based offsets of max/min from start_addr
module extrema_scan_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  n,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              empty_err,
  output logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] min,
  output logic [CNT_W-1:0]  max_idx,
  output logic [CNT_W-1:0]  min_idx
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  n_q, k_q, max_idx_q, min_idx_q;
  logic [DATA_W-1:0] max_q, min_q;
  logic              first_q, empty_q;
  logic [RD_LAT-1:0] vld_q, vld_sh;
  logic [CNT_W-1:0]  off_q [RD_LAT];
  logic              accept, last_issue, drained, ret_vld, gt, lt;
  logic [CNT_W-1:0]  ret_off;
  assign accept     = (state_q == IDLE) && start;
  assign last_issue = (state_q == ISSUE) && (k_q == n_q - CNT_W'(1));
  // the returning word sits in the top slot; drained once nothing remains behind it
  assign vld_sh     = vld_q << 1;
  assign drained    = (state_q == DRAIN) && (vld_sh == '0);
  assign ret_vld    = vld_q[RD_LAT-1];
  assign ret_off    = off_q[RD_LAT-1];
  assign gt = (SIGNED != 0) ? ($signed(rdata) > $signed(max_q)) : (rdata > max_q);
  assign lt = (SIGNED != 0) ? ($signed(rdata) < $signed(min_q)) : (rdata < min_q);
  always_comb begin
    state_d = accept ? ((n == '0) ? DONE : ISSUE) :
              last_issue ? DRAIN :
              drained ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  assign addr      = addr_q;
  assign rd_en     = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign empty_err = empty_q;
  assign max       = max_q;
  assign min       = min_q;
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      first_q   <= 1'b0;
      empty_q   <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      vld_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) off_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= start_addr;
        n_q     <= n;
        k_q     <= '0;
        first_q <= 1'b1;
        empty_q <= (n == '0);
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        k_q    <= k_q + CNT_W'(1);
      end
      vld_q[0] <= rd_en;
      off_q[0] <= k_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        off_q[i] <= off_q[i-1];
      end
      // strict compares keep the lowest offset on ties
      if (ret_vld) begin
        first_q <= 1'b0;
        if (first_q || gt) begin
          max_q     <= rdata;
          max_idx_q <= ret_off;
        end
        if (first_q || lt) begin
          min_q     <= rdata;
          min_idx_q <= ret_off;
        end
      end
    end
  end
endmodule
